// File: rtl/morse_symbol_decoder.sv
// Morse keyer front-end: synchronises and debounces a key, times marks/spaces and
// assembles dot/dash letters onto a valid/ready output. Optional: MORSE_ADAPTIVE_EN.
module morse_symbol_decoder #(
  parameter int DOT_TICKS = 10,
  parameter int CNT_W     = 16,
  parameter int MAX_SYM   = 6,
  parameter int DEB_N     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               key_in,
  input  logic               sym_ready,
  output logic               sym_valid,
  output logic [MAX_SYM-1:0] sym_code,
  output logic [2:0]         sym_len,
  output logic               sym_err,
  output logic               word_gap,
  output logic               overflow,
  output logic               key_db,
  output logic [CNT_W-1:0]   dot_unit
);
  localparam int TW    = CNT_W + 3;
  localparam int DEB_W = $clog2(DEB_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;
  state_t state_q, state_d;

  logic               sync_p0, sync_p1;
  logic [DEB_W-1:0]   deb_cnt;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAX_SYM-1:0] buf_q;
  logic [2:0]         elem_cnt;
  logic               err_q, armed_q, mark_pend_q;
  logic [TW-1:0]      cnt_x, two_u, five_u;
  logic               pending, space_end, gap_hit, is_dash;
  logic               do_append, do_emit, do_gap, set_mark_pend;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchroniser (free-running), then debounce (held by ena)
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      deb_cnt <= '0;
      key_db  <= 1'b0;
    end else begin
      sync_p0 <= key_in;
      sync_p1 <= sync_p0;
      if (ena) begin
        if (sync_p1 == key_db) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEB_N - 1)) begin
          key_db  <= sync_p1;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end
  end

  // Stage: mark/space timing and letter assembly
  assign cnt_x     = TW'(cnt_q);
  assign two_u     = TW'(dot_unit) << 1;
  assign five_u    = (TW'(dot_unit) << 2) + TW'(dot_unit);
  assign pending   = (elem_cnt != 3'd0);
  assign space_end = pending && (cnt_x >= two_u);
  assign gap_hit   = armed_q && (cnt_x >= five_u);
  assign is_dash   = (cnt_x >= two_u);

  always_ff @(posedge clk) begin
    if (rst)      state_q <= IDLE;
    else if (ena) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (key_db) state_d = MARK;
      MARK:  if (!key_db) state_d = SPACE;
      SPACE: begin
        if (space_end)    state_d = EMIT;
        else if (key_db)  state_d = MARK;
        else if (gap_hit) state_d = IDLE;
      end
      EMIT:  state_d = (key_db || mark_pend_q) ? MARK : SPACE;
      default: state_d = IDLE;
    endcase
  end

  // A key rise that ends a letter is already the first mark tick; mark_pend carries it through EMIT
  always_comb begin
    cnt_d         = sat_inc(cnt_q);
    do_append     = 1'b0;
    do_emit       = 1'b0;
    do_gap        = 1'b0;
    set_mark_pend = 1'b0;
    case (state_q)
      IDLE: cnt_d = CNT_W'(1);
      MARK: begin
        if (!key_db) begin
          do_append = 1'b1;
          cnt_d     = CNT_W'(1);
        end
      end
      SPACE: begin
        if (key_db) begin
          cnt_d         = CNT_W'(1);
          set_mark_pend = space_end;
        end else if (!space_end && gap_hit) begin
          do_gap = 1'b1;
        end
      end
      EMIT: begin
        do_emit = 1'b1;
        if (mark_pend_q)  cnt_d = key_db ? sat_inc(cnt_q) : cnt_q;
        else if (key_db)  cnt_d = CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      buf_q       <= '0;
      elem_cnt    <= '0;
      err_q       <= 1'b0;
      armed_q     <= 1'b0;
      mark_pend_q <= 1'b0;
      sym_valid   <= 1'b0;
      sym_code    <= '0;
      sym_len     <= '0;
      sym_err     <= 1'b0;
      word_gap    <= 1'b0;
      overflow    <= 1'b0;
    end else if (ena) begin
      cnt_q       <= cnt_d;
      mark_pend_q <= set_mark_pend;
      word_gap    <= do_gap;
      overflow    <= 1'b0;
      if (do_gap) armed_q <= 1'b0;
      if (do_append) begin
        if (elem_cnt < 3'(MAX_SYM)) begin
          buf_q    <= (buf_q << 1) | MAX_SYM'(is_dash);
          elem_cnt <= elem_cnt + 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (sym_valid && sym_ready) sym_valid <= 1'b0;
      if (do_emit) begin
        armed_q <= 1'b1;
        if (!sym_valid || sym_ready) begin
          sym_valid <= 1'b1;
          sym_code  <= buf_q;
          sym_len   <= elem_cnt;
          sym_err   <= err_q;
        end else begin
          overflow <= 1'b1;
        end
        buf_q    <= '0;
        elem_cnt <= '0;
        err_q    <= 1'b0;
      end
    end
  end

`ifdef MORSE_ADAPTIVE_EN
  // Stage: dot-unit tracking, updated once per classified mark
  localparam logic [TW-1:0] DU_MIN = TW'(4);
  localparam logic [TW-1:0] DU_MAX = TW'(1) << (CNT_W - 3);

  logic [CNT_W-1:0] du_q;
  logic [TW-1:0]    du_sum;

  function automatic logic [CNT_W-1:0] clamp_unit(input logic [TW-1:0] v);
    if (v < DU_MIN)      return CNT_W'(DU_MIN);
    else if (v > DU_MAX) return CNT_W'(DU_MAX);
    else                 return CNT_W'(v);
  endfunction

  always_comb begin
    if (is_dash) du_sum = (TW'(du_q) << 1) + TW'(du_q) + TW'(cnt_q / CNT_W'(3));
    else         du_sum = (TW'(du_q) << 1) + TW'(du_q) + cnt_x;
  end

  always_ff @(posedge clk) begin
    if (rst)                    du_q <= CNT_W'(DOT_TICKS);
    else if (ena && do_append)  du_q <= clamp_unit(du_sum >> 2);
  end

  assign dot_unit = du_q;
`else
  assign dot_unit = CNT_W'(DOT_TICKS);
`endif

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Directed bench for morse_symbol_decoder (DOT_TICKS=10, MAX_SYM=6, DEB_N=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_morse_symbol_decoder;
  logic        clk = 1'b0;
  logic        rst, ena, key_in, sym_ready;
  logic        sym_valid, sym_err, word_gap, overflow, key_db;
  logic [5:0]  sym_code;
  logic [2:0]  sym_len;
  logic [15:0] dot_unit;
  int total = 0;
  int bad   = 0;

  morse_symbol_decoder #(.DOT_TICKS(10), .CNT_W(16), .MAX_SYM(6), .DEB_N(2)) dut (
    .clk(clk), .rst(rst), .ena(ena), .key_in(key_in), .sym_ready(sym_ready),
    .sym_valid(sym_valid), .sym_code(sym_code), .sym_len(sym_len), .sym_err(sym_err),
    .word_gap(word_gap), .overflow(overflow), .key_db(key_db), .dot_unit(dot_unit)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int limit, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < limit && !ok) begin
      tick(1);
      n++;
      if (sym_valid) ok = 1'b1;
    end
  endtask

  task automatic press(input int len);
    key_in = 1'b1;
    tick(len);
    key_in = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ena = 1'b1; key_in = 1'b0; sym_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    total++; if (sym_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", sym_valid); end
    total++; if (sym_code !== 6'd0) begin bad++; $display("FAIL rst_code got=%b want=000000", sym_code); end
    total++; if (sym_len !== 3'd0) begin bad++; $display("FAIL rst_len got=%0d want=0", sym_len); end
    total++; if (sym_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", sym_err); end
    total++; if (word_gap !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL rst_pulses got=%b%b want=00", word_gap, overflow); end
    total++; if (key_db !== 1'b0) begin bad++; $display("FAIL rst_key_db got=%b want=0", key_db); end
    total++; if (dot_unit !== 16'd10) begin bad++; $display("FAIL rst_dot_unit got=%0d want=10", dot_unit); end
  endtask

  // dot 10, gap 10, dash 30. Release edge -> key_db low after 4 edges, SPACE after 5,
  // space count reaches 20 and EMIT follows, sym_valid visible after edge 26.
  task automatic test_letter_a;
    int n; bit ok;
    press(10);
    tick(10);
    press(30);
    wait_valid(100, n, ok);
    total++; if (!ok) begin bad++; $display("FAIL a_timeout got=no_valid want=valid"); end
    total++; if (n !== 26) begin bad++; $display("FAIL a_latency got=%0d want=26", n); end
    total++; if (sym_len !== 3'd2) begin bad++; $display("FAIL a_len got=%0d want=2", sym_len); end
    total++; if (sym_code !== 6'b000001) begin bad++; $display("FAIL a_code got=%b want=000001", sym_code); end
    total++; if (sym_err !== 1'b0) begin bad++; $display("FAIL a_err got=%b want=0", sym_err); end
    tick(1);
    total++; if (sym_valid !== 1'b0) begin bad++; $display("FAIL a_accept got=%b want=0", sym_valid); end
  endtask

  task automatic test_word_gap;
    int pulses = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (word_gap) pulses++;
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL gap_first got=%0d want=1", pulses); end
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (word_gap) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL gap_repeat got=%0d want=0", pulses); end
  endtask

  task automatic test_backpressure;
    int n; bit ok;
    int ovf = 0;
    int unstable = 0;
    sym_ready = 1'b0;
    press(10);
    wait_valid(100, n, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_e_timeout got=no_valid want=valid"); end
    total++; if (sym_len !== 3'd1 || sym_code !== 6'd0) begin bad++; $display("FAIL bp_e_data got=len%0d/%b want=len1/000000", sym_len, sym_code); end
    key_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 30) key_in = 1'b0;
      tick(1);
      if (overflow) ovf++;
      if (!sym_valid || sym_len !== 3'd1 || sym_code !== 6'd0) unstable++;
    end
    total++; if (ovf !== 1) begin bad++; $display("FAIL bp_overflow got=%0d want=1", ovf); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", unstable); end
    sym_ready = 1'b1;
    tick(1);
    total++; if (sym_valid !== 1'b0) begin bad++; $display("FAIL bp_accept got=%b want=0", sym_valid); end
    tick(100);
  endtask

  task automatic test_length_limit;
    int n; bit ok;
    for (int i = 0; i < 7; i++) begin
      press(10);
      if (i < 6) tick(10);
    end
    wait_valid(100, n, ok);
    total++; if (!ok) begin bad++; $display("FAIL len_timeout got=no_valid want=valid"); end
    total++; if (sym_len !== 3'd6) begin bad++; $display("FAIL len_len got=%0d want=6", sym_len); end
    total++; if (sym_code !== 6'b000000) begin bad++; $display("FAIL len_code got=%b want=000000", sym_code); end
    total++; if (sym_err !== 1'b1) begin bad++; $display("FAIL len_err got=%b want=1", sym_err); end
    tick(100);
  endtask

  task automatic test_glitch;
    int seen = 0;
    press(1);
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (key_db || sym_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL glitch got=%0d want=0", seen); end
  endtask

  task automatic test_reset_mid_mark;
    int n; bit ok;
    key_in = 1'b1;
    tick(8);
    total++; if (key_db !== 1'b1) begin bad++; $display("FAIL rm_pressed got=%b want=1", key_db); end
    rst = 1'b1;
    key_in = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    total++; if (sym_valid !== 1'b0 || sym_len !== 3'd0 || sym_code !== 6'd0 || sym_err !== 1'b0) begin
      bad++; $display("FAIL rm_outputs got=%b/%0d/%b/%b want=0/0/000000/0", sym_valid, sym_len, sym_code, sym_err);
    end
    total++; if (key_db !== 1'b0 || word_gap !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL rm_flags got=%b%b%b want=000", key_db, word_gap, overflow);
    end
    total++; if (dot_unit !== 16'd10) begin bad++; $display("FAIL rm_dot_unit got=%0d want=10", dot_unit); end
    press(30);
    wait_valid(100, n, ok);
    total++; if (!ok) begin bad++; $display("FAIL rm_timeout got=no_valid want=valid"); end
    total++; if (sym_len !== 3'd1 || sym_code !== 6'b000001 || sym_err !== 1'b0) begin
      bad++; $display("FAIL rm_letter got=len%0d/%b/%b want=len1/000001/0", sym_len, sym_code, sym_err);
    end
    tick(100);
  endtask

  // Raw press of 50 ticks with 40 of them frozen: only ~10 counted, so a dot.
  task automatic test_ena_hold;
    int n; bit ok;
    key_in = 1'b1;
    tick(6);
    ena = 1'b0;
    tick(40);
    ena = 1'b1;
    tick(4);
    key_in = 1'b0;
    wait_valid(100, n, ok);
    total++; if (!ok) begin bad++; $display("FAIL ena_timeout got=no_valid want=valid"); end
    total++; if (sym_len !== 3'd1 || sym_code !== 6'd0) begin
      bad++; $display("FAIL ena_letter got=len%0d/%b want=len1/000000", sym_len, sym_code);
    end
    tick(100);
  endtask

`ifdef MORSE_ADAPTIVE_EN
  // 18-tick dot: (30+18)>>2=12; 60-tick dash: (36+20)>>2=14; 20-tick dot: (42+20)>>2=15.
  task automatic test_adaptive;
    int n; bit ok;
    press(18);
    wait_valid(100, n, ok);
    total++; if (!ok || sym_code !== 6'd0 || dot_unit !== 16'd12) begin
      bad++; $display("FAIL adapt_dot got=%0d/%b want=12/000000", dot_unit, sym_code);
    end
    tick(150);
    press(60);
    wait_valid(100, n, ok);
    total++; if (!ok || sym_code !== 6'd1 || dot_unit !== 16'd14) begin
      bad++; $display("FAIL adapt_dash got=%0d/%b want=14/000001", dot_unit, sym_code);
    end
    tick(150);
    press(20);
    wait_valid(100, n, ok);
    total++; if (!ok || sym_code !== 6'd0 || dot_unit !== 16'd15) begin
      bad++; $display("FAIL adapt_dot2 got=%0d/%b want=15/000000", dot_unit, sym_code);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_letter_a;
    test_word_gap;
    test_backpressure;
    test_length_limit;
    test_glitch;
    test_reset_mid_mark;
    test_ena_hold;
`ifdef MORSE_ADAPTIVE_EN
    test_adaptive;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
